// File: rtl/mcast_pkg.sv
// Shared types and constants for the MultiCaster bus driver.
// Holds the FSM state encoding, CASTER_EN bit positions and the psum width rule.
package mcast_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam int EN_WIDTH = 3;
    localparam int EN_IFMAP = 0;
    localparam int EN_FLTR  = 1;
    localparam int EN_PSUM  = 2;

    // A psum carries a full product, so it is twice the operand width.
    function automatic int psum_width(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/mcast_bus_driver_slot.sv
// One-word holding register for a valid/ready stream.
// It accepts a word only while enabled and empty, and empties on clear.
module stream_hold_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clear,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             fill,
    output logic             full,
    output logic [WIDTH-1:0] dout
);

    logic             full_reg;
    logic [WIDTH-1:0] data_reg;

    assign ready = en && !full_reg;
    assign fill  = valid && ready;
    assign full  = full_reg;
    assign dout  = data_reg;

    // The word itself is kept after clear so the caster-side outputs never glitch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else begin
            if (clear) begin
                full_reg <= 1'b0;
            end else if (fill) begin
                full_reg <= 1'b1;
            end
            if (fill) begin
                data_reg <= data;
            end
        end
    end

endmodule

// File: rtl/mcast_bus_driver.sv
// Bus-side initiator for the three-stream MultiCaster: gathers ifmap/filter/psum,
// issues them to the caster, waits for the result and returns it to the psum buffer.
module mcast_bus_driver
    import mcast_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    num_ops,
    output logic                    busy,
    output logic                    done,
    output logic                    proto_err,
    input  logic                    ifmap_valid,
    output logic                    ifmap_ready,
    input  logic [DATA_WIDTH-1:0]   ifmap_data,
    input  logic                    fltr_valid,
    output logic                    fltr_ready,
    input  logic [DATA_WIDTH-1:0]   fltr_data,
    input  logic                    psum_in_valid,
    output logic                    psum_in_ready,
    input  logic [2*DATA_WIDTH-1:0] psum_in_data,
    output logic                    psum_out_valid,
    input  logic                    psum_out_ready,
    output logic [2*DATA_WIDTH-1:0] psum_out_data,
    output logic [2:0]              CASTER_EN,
    output logic [DATA_WIDTH-1:0]   ifmap_data_M2B,
    output logic [DATA_WIDTH-1:0]   fltr_data_M2B,
    output logic [2*DATA_WIDTH-1:0] psum_data_M2B,
    input  logic                    CASTER_READY,
    input  logic                    CASTER_VALID,
    input  logic [2*DATA_WIDTH-1:0] psum_data_B2M
);

    localparam int PSUM_WIDTH = psum_width(DATA_WIDTH);

    state_t                  state_reg;
    logic [CNT_WIDTH-1:0]    num_ops_reg;
    logic [CNT_WIDTH-1:0]    cnt_reg;
    logic [PSUM_WIDTH-1:0]   result_reg;
    logic [EN_WIDTH-1:0]     caster_en_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    psum_out_valid_reg;
    logic                    proto_err_reg;

    logic                    slot_en;
    logic                    slot_clear;
    logic                    ifmap_fill, fltr_fill, psum_fill;
    logic                    ifmap_full, fltr_full, psum_full;
    logic                    all_full_next;
    logic                    last_op;

    assign slot_en    = (state_reg == ST_LOAD);
    assign slot_clear = (state_reg == ST_ISSUE) && CASTER_READY;

    stream_hold_slot #(.WIDTH(DATA_WIDTH)) u_ifmap_slot (
        .clk   (clk),
        .rstn  (rstn),
        .en    (slot_en),
        .clear (slot_clear),
        .valid (ifmap_valid),
        .data  (ifmap_data),
        .ready (ifmap_ready),
        .fill  (ifmap_fill),
        .full  (ifmap_full),
        .dout  (ifmap_data_M2B)
    );

    stream_hold_slot #(.WIDTH(DATA_WIDTH)) u_fltr_slot (
        .clk   (clk),
        .rstn  (rstn),
        .en    (slot_en),
        .clear (slot_clear),
        .valid (fltr_valid),
        .data  (fltr_data),
        .ready (fltr_ready),
        .fill  (fltr_fill),
        .full  (fltr_full),
        .dout  (fltr_data_M2B)
    );

    stream_hold_slot #(.WIDTH(PSUM_WIDTH)) u_psum_slot (
        .clk   (clk),
        .rstn  (rstn),
        .en    (slot_en),
        .clear (slot_clear),
        .valid (psum_in_valid),
        .data  (psum_in_data),
        .ready (psum_in_ready),
        .fill  (psum_fill),
        .full  (psum_full),
        .dout  (psum_data_M2B)
    );

    // Looking at the slot contents after this edge lets LOAD finish in a single
    // cycle when every stream is already presenting a word.
    assign all_full_next = (ifmap_full || ifmap_fill)
                        && (fltr_full  || fltr_fill)
                        && (psum_full  || psum_fill);

    assign last_op = (cnt_reg == (num_ops_reg - CNT_WIDTH'(1)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg          <= ST_IDLE;
            num_ops_reg        <= '0;
            cnt_reg            <= '0;
            result_reg         <= '0;
            caster_en_reg      <= '0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            psum_out_valid_reg <= 1'b0;
            proto_err_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // A result strobe is only legal while a result is outstanding.
            if (CASTER_VALID && (state_reg != ST_WAIT)) begin
                proto_err_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (num_ops != '0) begin
                            num_ops_reg <= num_ops;
                            cnt_reg     <= '0;
                            busy_reg    <= 1'b1;
                            state_reg   <= ST_LOAD;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (all_full_next) begin
                        caster_en_reg[EN_IFMAP] <= 1'b1;
                        caster_en_reg[EN_FLTR]  <= 1'b1;
                        caster_en_reg[EN_PSUM]  <= 1'b1;
                        state_reg               <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (CASTER_READY) begin
                        caster_en_reg <= '0;
                        state_reg     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (CASTER_VALID) begin
                        result_reg         <= psum_data_B2M;
                        psum_out_valid_reg <= 1'b1;
                        state_reg          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (psum_out_ready) begin
                        psum_out_valid_reg <= 1'b0;
                        if (last_op) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            cnt_reg   <= cnt_reg + CNT_WIDTH'(1);
                            state_reg <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    caster_en_reg      <= '0;
                    busy_reg           <= 1'b0;
                    psum_out_valid_reg <= 1'b0;
                    state_reg          <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign proto_err      = proto_err_reg;
    assign CASTER_EN      = caster_en_reg;
    assign psum_out_valid = psum_out_valid_reg;
    assign psum_out_data  = result_reg;

endmodule

// File: tb/tb_mcast_bus_driver.sv
// Directed-vector bench for mcast_bus_driver: single op, staggered streams with
// backpressure, a multi-op job, num_ops=0, protocol error and reset mid-WAIT.
module tb_mcast_bus_driver;

    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [CW-1:0] num_ops;
    logic          busy, done, proto_err;
    logic          ifmap_valid, ifmap_ready;
    logic [DW-1:0] ifmap_data;
    logic          fltr_valid, fltr_ready;
    logic [DW-1:0] fltr_data;
    logic          psum_in_valid, psum_in_ready;
    logic [2*DW-1:0] psum_in_data;
    logic          psum_out_valid, psum_out_ready;
    logic [2*DW-1:0] psum_out_data;
    logic [2:0]    CASTER_EN;
    logic [DW-1:0] ifmap_data_M2B, fltr_data_M2B;
    logic [2*DW-1:0] psum_data_M2B;
    logic          CASTER_READY, CASTER_VALID;
    logic [2*DW-1:0] psum_data_B2M;

    int n_vec = 0;
    int n_err = 0;
    int issue_cnt, out_cnt;

    always #5 clk = ~clk;

    mcast_bus_driver #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .num_ops        (num_ops),
        .busy           (busy),
        .done           (done),
        .proto_err      (proto_err),
        .ifmap_valid    (ifmap_valid),
        .ifmap_ready    (ifmap_ready),
        .ifmap_data     (ifmap_data),
        .fltr_valid     (fltr_valid),
        .fltr_ready     (fltr_ready),
        .fltr_data      (fltr_data),
        .psum_in_valid  (psum_in_valid),
        .psum_in_ready  (psum_in_ready),
        .psum_in_data   (psum_in_data),
        .psum_out_valid (psum_out_valid),
        .psum_out_ready (psum_out_ready),
        .psum_out_data  (psum_out_data),
        .CASTER_EN      (CASTER_EN),
        .ifmap_data_M2B (ifmap_data_M2B),
        .fltr_data_M2B  (fltr_data_M2B),
        .psum_data_M2B  (psum_data_M2B),
        .CASTER_READY   (CASTER_READY),
        .CASTER_VALID   (CASTER_VALID),
        .psum_data_B2M  (psum_data_B2M)
    );

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] readys();
        return {psum_in_ready, fltr_ready, ifmap_ready};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start = 1'b0; num_ops = '0;
        ifmap_valid = 1'b0; ifmap_data = '0;
        fltr_valid = 1'b0; fltr_data = '0;
        psum_in_valid = 1'b0; psum_in_data = '0;
        psum_out_ready = 1'b0;
        CASTER_READY = 1'b0; CASTER_VALID = 1'b0; psum_data_B2M = '0;

        // Reset state
        repeat (2) tick();
        check_vec("rst_busy", busy, 0);
        check_vec("rst_done", done, 0);
        check_vec("rst_en", CASTER_EN, 0);
        check_vec("rst_pov", psum_out_valid, 0);
        check_vec("rst_pod", psum_out_data, 0);
        check_vec("rst_perr", proto_err, 0);
        check_vec("rst_readys", readys(), 0);
        check_vec("rst_m2b", {ifmap_data_M2B, fltr_data_M2B, psum_data_M2B}, 0);
        rstn = 1'b1;
        tick();

        // Single op, all valids at once
        num_ops = 1; start = 1'b1;
        ifmap_valid = 1'b1; ifmap_data = 16'h0003;
        fltr_valid = 1'b1; fltr_data = 16'h0004;
        psum_in_valid = 1'b1; psum_in_data = 32'h0000_0010;
        CASTER_READY = 1'b1; psum_out_ready = 1'b1;
        tick();
        start = 1'b0;
        check_vec("s1_load_busy", busy, 1);
        check_vec("s1_load_readys", readys(), 3'b111);
        check_vec("s1_load_en", CASTER_EN, 0);
        tick();
        ifmap_valid = 1'b0; fltr_valid = 1'b0; psum_in_valid = 1'b0;
        check_vec("s1_issue_en", CASTER_EN, 3'b111);
        check_vec("s1_issue_readys", readys(), 0);
        check_vec("s1_ifmap_m2b", ifmap_data_M2B, 16'h0003);
        check_vec("s1_fltr_m2b", fltr_data_M2B, 16'h0004);
        check_vec("s1_psum_m2b", psum_data_M2B, 32'h0000_0010);
        tick();
        check_vec("s1_wait_en", CASTER_EN, 0);
        CASTER_VALID = 1'b1; psum_data_B2M = 32'h0000_001C;
        tick();
        CASTER_VALID = 1'b0;
        check_vec("s1_resp_pov", psum_out_valid, 1);
        check_vec("s1_resp_pod", psum_out_data, 32'h0000_001C);
        check_vec("s1_resp_done", done, 0);
        tick();
        check_vec("s1_done", done, 1);
        check_vec("s1_idle_busy", busy, 0);
        check_vec("s1_idle_pov", psum_out_valid, 0);
        tick();
        check_vec("s1_done_drop", done, 0);

        // Staggered streams, then 3 cycles of CASTER_READY low
        CASTER_READY = 1'b0; psum_out_ready = 1'b0;
        num_ops = 1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ifmap_valid   = (k == 0);
            ifmap_data    = (k == 0) ? 16'h00A1 : 16'hFFFF;
            psum_in_valid = (k == 2);
            psum_in_data  = (k == 2) ? 32'h0000_00C3 : 32'hFFFF_FFFF;
            fltr_valid    = (k == 5);
            fltr_data     = (k == 5) ? 16'h00B2 : 16'hFFFF;
            CASTER_READY  = (k == 9);
            check_vec($sformatf("st_readys_t%0d", k), readys(),
                      {1'(k <= 2), 1'(k <= 5), 1'(k == 0)});
            check_vec($sformatf("st_en_t%0d", k), CASTER_EN, (k >= 6) ? 3'b111 : 3'b000);
            if (k >= 6) begin
                check_vec($sformatf("st_m2b_t%0d", k),
                          {ifmap_data_M2B, fltr_data_M2B, psum_data_M2B},
                          {16'h00A1, 16'h00B2, 32'h0000_00C3});
            end
            tick();
        end
        ifmap_valid = 1'b0; fltr_valid = 1'b0; psum_in_valid = 1'b0;
        CASTER_READY = 1'b0;
        check_vec("st_wait_en", CASTER_EN, 0);
        CASTER_VALID = 1'b1; psum_data_B2M = 32'h1234_5678;
        tick();
        CASTER_VALID = 1'b0; psum_data_B2M = 32'h0;
        for (int j = 0; j < 3; j++) begin
            psum_out_ready = (j == 2);
            check_vec($sformatf("bp_pov_%0d", j), psum_out_valid, 1);
            check_vec($sformatf("bp_pod_%0d", j), psum_out_data, 32'h1234_5678);
            check_vec($sformatf("bp_readys_%0d", j), readys(), 0);
            tick();
        end
        psum_out_ready = 1'b0;
        check_vec("bp_done", done, 1);
        check_vec("bp_busy", busy, 0);
        tick();

        // Multi-op job with continuous valids, start pulsed mid-job
        ifmap_valid = 1'b1; ifmap_data = 16'h0001;
        fltr_valid = 1'b1; fltr_data = 16'h0002;
        psum_in_valid = 1'b1; psum_in_data = 32'h0000_0003;
        CASTER_READY = 1'b1; psum_out_ready = 1'b1;
        num_ops = 3; start = 1'b1;
        tick();
        start = 1'b0;
        issue_cnt = 0; out_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            int  ph;
            bit  live;
            ph   = c % 4;
            live = (c < 12);
            start         = (c == 5);
            num_ops       = (c == 5) ? 16'd7 : 16'd3;
            CASTER_VALID  = live && (ph == 2);
            psum_data_B2M = 32'h100 + 32'(c / 4);
            check_vec($sformatf("mo_en_c%0d", c), CASTER_EN, (live && ph == 1) ? 3'b111 : 3'b000);
            check_vec($sformatf("mo_pov_c%0d", c), psum_out_valid, live && (ph == 3));
            check_vec($sformatf("mo_done_c%0d", c), done, c == 12);
            check_vec($sformatf("mo_busy_c%0d", c), busy, live);
            if (live && ph == 3) begin
                check_vec($sformatf("mo_pod_c%0d", c), psum_out_data, 32'h100 + 32'(c / 4));
            end
            if (CASTER_EN == 3'b111 && CASTER_READY) issue_cnt++;
            if (psum_out_valid && psum_out_ready) out_cnt++;
            tick();
        end
        start = 1'b0; CASTER_VALID = 1'b0;
        ifmap_valid = 1'b0; fltr_valid = 1'b0; psum_in_valid = 1'b0;
        check_vec("mo_issue_cnt", issue_cnt, 3);
        check_vec("mo_out_cnt", out_cnt, 3);
        check_vec("mo_idle_busy", busy, 0);
        check_vec("mo_perr", proto_err, 0);

        // num_ops = 0
        num_ops = 0; start = 1'b1;
        tick();
        start = 1'b0;
        check_vec("z_done", done, 1);
        check_vec("z_busy", busy, 0);
        tick();
        check_vec("z_done_drop", done, 0);
        check_vec("z_busy2", busy, 0);

        // CASTER_VALID during LOAD
        num_ops = 1; start = 1'b1;
        tick();
        start = 1'b0;
        CASTER_VALID = 1'b1;
        check_vec("pe_before", proto_err, 0);
        tick();
        CASTER_VALID = 1'b0;
        check_vec("pe_set", proto_err, 1);
        check_vec("pe_busy", busy, 1);
        check_vec("pe_readys", readys(), 3'b111);
        check_vec("pe_en", CASTER_EN, 0);
        tick(); tick();
        check_vec("pe_sticky", proto_err, 1);
        check_vec("pe_still_load", readys(), 3'b111);

        // Finish gathering, issue, then reset mid-WAIT
        ifmap_valid = 1'b1; ifmap_data = 16'h0005;
        fltr_valid = 1'b1; fltr_data = 16'h0006;
        psum_in_valid = 1'b1; psum_in_data = 32'h0000_0007;
        CASTER_READY = 1'b1;
        tick();
        ifmap_valid = 1'b0; fltr_valid = 1'b0; psum_in_valid = 1'b0;
        check_vec("rw_issue_en", CASTER_EN, 3'b111);
        tick();
        check_vec("rw_wait_en", CASTER_EN, 0);
        check_vec("rw_wait_busy", busy, 1);
        #3 rstn = 1'b0;
        #1;
        check_vec("rw_async_busy", busy, 0);
        check_vec("rw_async_en", CASTER_EN, 0);
        check_vec("rw_async_perr", proto_err, 0);
        check_vec("rw_async_m2b", ifmap_data_M2B, 0);
        tick();
        check_vec("rw_rst_done", done, 0);
        rstn = 1'b1;
        tick();
        check_vec("rw_post_done", done, 0);
        check_vec("rw_post_busy", busy, 0);

        // Fresh job after reset
        num_ops = 1; start = 1'b1;
        ifmap_valid = 1'b1; ifmap_data = 16'h0009;
        fltr_valid = 1'b1; fltr_data = 16'h000A;
        psum_in_valid = 1'b1; psum_in_data = 32'h0000_000B;
        CASTER_READY = 1'b1; psum_out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ifmap_valid = 1'b0; fltr_valid = 1'b0; psum_in_valid = 1'b0;
        check_vec("fr_issue_en", CASTER_EN, 3'b111);
        check_vec("fr_m2b", {ifmap_data_M2B, fltr_data_M2B, psum_data_M2B},
                  {16'h0009, 16'h000A, 32'h0000_000B});
        tick();
        CASTER_VALID = 1'b1; psum_data_B2M = 32'h0000_ABCD;
        tick();
        CASTER_VALID = 1'b0;
        check_vec("fr_pod", psum_out_data, 32'h0000_ABCD);
        check_vec("fr_pov", psum_out_valid, 1);
        tick();
        check_vec("fr_done", done, 1);
        check_vec("fr_perr", proto_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
